// File: rtl/pe_accumulator.sv
// pe_accumulator: sums i_len products into a wide accumulator over valid/ready handshakes; PE_ACC_SATURATE_EN enables saturating adds and o_ovf
module pe_accumulator #(
  parameter int SIGNED = 1,
  parameter int MUL_W  = 32,
  parameter int ACC_W  = 48,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en_ff,
  input  logic             i_start,
  input  logic [CNT_W-1:0] i_len,
  input  logic             i_prod_valid,
  input  logic [MUL_W-1:0] i_prod,
  output logic             o_prod_ready,
  output logic             o_busy,
  output logic             o_acc_valid,
  output logic [ACC_W-1:0] o_acc,
  input  logic             i_acc_ready,
  output logic             o_ovf
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;
  state_t r_state, w_next_state;
  logic [ACC_W-1:0] r_acc, w_ext, w_acc_next;
  logic [CNT_W-1:0] r_cnt;
  logic signed [MUL_W-1:0] w_sprod;
  logic w_take, w_fire, w_start, w_last;
  assign w_sprod = i_prod;
  assign w_ext = (SIGNED != 0) ? ACC_W'(w_sprod) : ACC_W'(i_prod);
  assign w_take = (r_state == S_ACCUM) & i_prod_valid & i_en_ff;
  assign w_fire = (r_state == S_DONE) & i_acc_ready & i_en_ff;
  assign w_start = i_en_ff & i_start & ((r_state == S_IDLE) | w_fire);
  assign w_last = w_take & (r_cnt == CNT_W'(1));
  assign o_acc = r_acc;
`ifdef PE_ACC_SATURATE_EN
  logic [ACC_W:0] w_sum;
  logic w_ovf, r_ovf;
  assign w_sum = {1'b0, r_acc} + {1'b0, w_ext};
  // detect overflow of the add and clamp toward the side it overflowed from
  always_comb begin
    w_ovf = (SIGNED != 0) ? (r_acc[ACC_W-1] == w_ext[ACC_W-1]) & (w_sum[ACC_W-1] != r_acc[ACC_W-1]) : w_sum[ACC_W];
    w_acc_next = !w_ovf ? w_sum[ACC_W-1:0] : (SIGNED != 0) ? {r_acc[ACC_W-1], {(ACC_W-1){~r_acc[ACC_W-1]}}} : '1;
  end
  // sticky overflow, cleared whenever a new result begins or the old one leaves
  always_ff @(posedge i_clk) begin
    if (i_rst | w_start | w_fire) r_ovf <= 1'b0;
    else if (w_take & w_ovf) r_ovf <= 1'b1;
  end
  assign o_ovf = r_ovf;
`else
  assign w_acc_next = r_acc + w_ext;
  assign o_ovf = 1'b0;
`endif
  // state register; a stall freezes the FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else if (i_en_ff) r_state <= w_next_state;
  end
  // next state: a start wins over the plain result handshake to allow back-to-back runs
  always_comb begin
    w_next_state = w_start ? ((i_len == '0) ? S_DONE : S_ACCUM) : w_fire ? S_IDLE : w_last ? S_DONE : r_state;
  end
  // handshake outputs decoded from registered state only
  always_comb begin
    o_prod_ready = r_state == S_ACCUM;
    o_acc_valid = r_state == S_DONE;
    o_busy = r_state != S_IDLE;
  end
  // accumulator and remaining-product counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_start | w_fire) begin
      r_acc <= '0;
      r_cnt <= w_start ? i_len : '0;
    end else if (w_take) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_pe_accumulator.sv
// tb_pe_accumulator: scoreboard bench for pe_accumulator across signed, narrow-overflow and unsigned configurations
module tb_pe_accumulator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;

  logic a_en = 1'b1, a_start = 1'b0, a_pv = 1'b0, a_ar = 1'b1;
  logic [15:0] a_len = '0;
  logic [31:0] a_prod = '0;
  logic a_pr, a_busy, a_av, a_ovf;
  logic [47:0] a_acc;
  logic b_en = 1'b1, b_start = 1'b0, b_pv = 1'b0, b_ar = 1'b1;
  logic [15:0] b_len = '0;
  logic [7:0] b_prod = '0;
  logic b_pr, b_busy, b_av, b_ovf;
  logic [7:0] b_acc;
  logic c_en = 1'b1, c_start = 1'b0, c_pv = 1'b0, c_ar = 1'b1;
  logic [15:0] c_len = '0;
  logic [31:0] c_prod = '0;
  logic c_pr, c_busy, c_av, c_ovf;
  logic [47:0] c_acc;

  pe_accumulator #(.SIGNED(1), .MUL_W(32), .ACC_W(48), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_en_ff(a_en), .i_start(a_start), .i_len(a_len),
    .i_prod_valid(a_pv), .i_prod(a_prod), .o_prod_ready(a_pr), .o_busy(a_busy),
    .o_acc_valid(a_av), .o_acc(a_acc), .i_acc_ready(a_ar), .o_ovf(a_ovf));
  pe_accumulator #(.SIGNED(1), .MUL_W(8), .ACC_W(8), .CNT_W(16)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en_ff(b_en), .i_start(b_start), .i_len(b_len),
    .i_prod_valid(b_pv), .i_prod(b_prod), .o_prod_ready(b_pr), .o_busy(b_busy),
    .o_acc_valid(b_av), .o_acc(b_acc), .i_acc_ready(b_ar), .o_ovf(b_ovf));
  pe_accumulator #(.SIGNED(0), .MUL_W(32), .ACC_W(48), .CNT_W(16)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_en_ff(c_en), .i_start(c_start), .i_len(c_len),
    .i_prod_valid(c_pv), .i_prod(c_prod), .o_prod_ready(c_pr), .o_busy(c_busy),
    .o_acc_valid(c_av), .o_acc(c_acc), .i_acc_ready(c_ar), .o_ovf(c_ovf));

  logic [48:0] qa[$];
  logic [8:0] qb[$];
  logic [48:0] qc[$];
  logic [48:0] ea, ec;
  logic [8:0] eb;

`ifdef PE_ACC_SATURATE_EN
  localparam logic [8:0] B_POS = {1'b1, 8'h7F};
  localparam logic [8:0] B_NEG = {1'b1, 8'h80};
  localparam logic [8:0] B_CONT = {1'b1, 8'h7E};
`else
  localparam logic [8:0] B_POS = {1'b0, 8'hC8};
  localparam logic [8:0] B_NEG = {1'b0, 8'h38};
  localparam logic [8:0] B_CONT = {1'b0, 8'hC7};
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic no_result(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got a result with an empty scoreboard, required none", name);
  endtask

  always @(negedge clk) if (!rst && a_en && a_av && a_ar) begin
    if (qa.size() == 0) no_result("a_unexpected");
    else begin
      ea = qa.pop_front();
      chk("a_result_acc", 64'(a_acc), 64'(ea[47:0]));
      chk("a_result_ovf", 64'(a_ovf), 64'(ea[48]));
    end
  end
  always @(negedge clk) if (!rst && b_en && b_av && b_ar) begin
    if (qb.size() == 0) no_result("b_unexpected");
    else begin
      eb = qb.pop_front();
      chk("b_result_acc", 64'(b_acc), 64'(eb[7:0]));
      chk("b_result_ovf", 64'(b_ovf), 64'(eb[8]));
    end
  end
  always @(negedge clk) if (!rst && c_en && c_av && c_ar) begin
    if (qc.size() == 0) no_result("c_unexpected");
    else begin
      ec = qc.pop_front();
      chk("c_result_acc", 64'(c_acc), 64'(ec[47:0]));
      chk("c_result_ovf", 64'(c_ovf), 64'(ec[48]));
    end
  end

  task automatic a_reset_outputs(input string name);
    chk({name, "_acc"}, 64'(a_acc), 0);
    chk({name, "_valid"}, 64'(a_av), 0);
    chk({name, "_ready"}, 64'(a_pr), 0);
    chk({name, "_busy"}, 64'(a_busy), 0);
    chk({name, "_ovf"}, 64'(a_ovf), 0);
  endtask

  task automatic run_b(input logic [15:0] n, input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input logic [8:0] exp);
    qb.push_back(exp);
    b_start = 1'b1;
    b_len = n;
    tick;
    b_start = 1'b0;
    b_pv = 1'b1;
    for (int i = 0; i < int'(n); i++) begin
      b_prod = (i == 0) ? p0 : (i == 1) ? p1 : p2;
      tick;
    end
    b_pv = 1'b0;
    chk("b_valid_after_last", 64'(b_av), 1);
    tick;
    tick;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick;
    a_reset_outputs("reset");
    rst = 1'b0;
    tick;
    // basic signed sum 5 - 3 + 100 - 2
    qa.push_back({1'b0, 48'd100});
    a_start = 1'b1;
    a_len = 16'd4;
    tick;
    a_start = 1'b0;
    chk("start_ready_next", 64'(a_pr), 1);
    chk("start_busy_next", 64'(a_busy), 1);
    a_pv = 1'b1;
    a_prod = 32'd5;
    tick;
    a_prod = 32'hFFFF_FFFD;
    tick;
    a_prod = 32'd100;
    tick;
    chk("valid_not_early", 64'(a_av), 0);
    a_prod = 32'hFFFF_FFFE;
    tick;
    a_pv = 1'b0;
    chk("valid_after_last", 64'(a_av), 1);
    chk("ready_low_done", 64'(a_pr), 0);
    tick;
    chk("valid_one_cycle", 64'(a_av), 0);
    chk("idle_not_busy", 64'(a_busy), 0);
    // bubbles and backpressure
    a_ar = 1'b0;
    qa.push_back({1'b0, 48'd27});
    a_start = 1'b1;
    a_len = 16'd3;
    tick;
    a_start = 1'b0;
    a_pv = 1'b1;
    a_prod = 32'd7;
    tick;
    a_pv = 1'b0;
    a_prod = 32'd0;
    tick;
    tick;
    a_pv = 1'b1;
    a_prod = 32'd9;
    tick;
    a_prod = 32'd11;
    tick;
    a_prod = 32'd1000;
    for (int i = 0; i < 5; i++) begin
      chk("bp_acc_hold", 64'(a_acc), 27);
      chk("bp_valid_hold", 64'(a_av), 1);
      chk("bp_ready_low", 64'(a_pr), 0);
      tick;
    end
    a_pv = 1'b0;
    a_ar = 1'b1;
    tick;
    chk("bp_released", 64'(a_av), 0);
    // back-to-back restart from DONE
    qa.push_back({1'b0, 48'd50});
    a_start = 1'b1;
    a_len = 16'd1;
    tick;
    a_start = 1'b0;
    a_pv = 1'b1;
    a_prod = 32'd50;
    tick;
    a_pv = 1'b0;
    qa.push_back({1'b0, 48'd3});
    a_start = 1'b1;
    a_len = 16'd2;
    tick;
    a_start = 1'b0;
    chk("b2b_busy", 64'(a_busy), 1);
    chk("b2b_ready", 64'(a_pr), 1);
    chk("b2b_acc_cleared", 64'(a_acc), 0);
    a_pv = 1'b1;
    a_prod = 32'd1;
    tick;
    a_prod = 32'd2;
    tick;
    a_pv = 1'b0;
    chk("b2b_valid", 64'(a_av), 1);
    tick;
    // zero length
    qa.push_back({1'b0, 48'd0});
    a_start = 1'b1;
    a_len = 16'd0;
    tick;
    a_start = 1'b0;
    chk("zero_len_valid", 64'(a_av), 1);
    tick;
    chk("zero_len_done", 64'(a_av), 0);
    // stall mid-ACCUM and in DONE
    qa.push_back({1'b0, 48'd30});
    a_start = 1'b1;
    a_len = 16'd2;
    tick;
    a_start = 1'b0;
    a_pv = 1'b1;
    a_prod = 32'd10;
    tick;
    a_en = 1'b0;
    a_prod = 32'd20;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_acc_hold", 64'(a_acc), 10);
      chk("stall_ready_hold", 64'(a_pr), 1);
    end
    a_en = 1'b1;
    tick;
    a_pv = 1'b0;
    chk("stall_resume_valid", 64'(a_av), 1);
    a_en = 1'b0;
    tick;
    chk("stall_done_valid", 64'(a_av), 1);
    chk("stall_done_acc", 64'(a_acc), 30);
    a_en = 1'b1;
    tick;
    chk("stall_done_released", 64'(a_av), 0);
    // reset mid-ACCUM discards the partial sum
    a_start = 1'b1;
    a_len = 16'd3;
    tick;
    a_start = 1'b0;
    a_pv = 1'b1;
    a_prod = 32'd5;
    tick;
    rst = 1'b1;
    tick;
    a_pv = 1'b0;
    a_reset_outputs("mid_rst");
    rst = 1'b0;
    tick;
    // narrow signed overflow, continuation from clamp, and flag clearing
    run_b(16'd2, 8'd100, 8'd100, 8'd0, B_POS);
    run_b(16'd2, 8'h9C, 8'h9C, 8'd0, B_NEG);
    run_b(16'd3, 8'd100, 8'd100, 8'hFF, B_CONT);
    run_b(16'd2, 8'd1, 8'd1, 8'd0, {1'b0, 8'd2});
    // unsigned zero extension
    qc.push_back({1'b0, 48'h1_FFFF_FFFE});
    c_start = 1'b1;
    c_len = 16'd2;
    tick;
    c_start = 1'b0;
    c_pv = 1'b1;
    c_prod = 32'hFFFF_FFFF;
    tick;
    tick;
    c_pv = 1'b0;
    chk("c_valid_after_last", 64'(c_av), 1);
    repeat (3) tick;
    chk("a_queue_drained", 64'(qa.size()), 0);
    chk("b_queue_drained", 64'(qb.size()), 0);
    chk("c_queue_drained", 64'(qc.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
